mem_arbiter: RTL and testbench

- Single-port memory arbiter directly downstream of the instruction cache and data cache.
- Accepts icache fill requests (iREN/iaddr) and dcache read/write requests (dREN/dWEN/daddr/dstore).
- Serialises them onto one RAM port and returns completion (wait low) plus load data to the granted client.
- Grants are registered: one FSM owns the RAM port until RAM reports ACCESS. A starvation counter bounds icache latency under sustained dcache traffic.

---
 rtl/cpu_types_pkg.sv | 44 ++++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the cache-to-memory interface and the memory arbiter FSM.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE,
        IGNT,
        DRGNT,
        DWGNT,
        RETRY
    } arb_state_t;

    // Which grant a RETRY cycle must return to.
    typedef enum logic [1:0] {
        GNT_I,
        GNT_DR,
        GNT_DW
    } grant_t;

    function automatic grant_t grant_of(input arb_state_t s);
        case (s)
            IGNT:    return GNT_I;
            DRGNT:   return GNT_DR;
            default: return GNT_DW;
        endcase
    endfunction

    function automatic arb_state_t state_of(input grant_t g);
        case (g)
            GNT_I:   return IGNT;
            GNT_DR:  return DRGNT;
            default: return DWGNT;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates icache fills and dcache reads/writes onto a single RAM port,
// with a starvation counter that bounds icache latency under dcache load.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t       state_reg, state_next;
    grant_t           saved_reg;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    word_t            addr_reg, data_reg;
    logic             ren_reg, wen_reg;
    logic             starved, i_done, dr_done, dw_done;

    assign starved = iREN && (cnt_reg == LIMIT);

    // Count applied on a D grant: grows only while the icache is left waiting.
    assign cnt_next = !iREN ? '0 :
                      (cnt_reg == LIMIT) ? LIMIT : cnt_reg + CNT_W'(1);

    // A reader that withdrew never sees a completion, even if ACCESS arrives.
    assign i_done  = (state_reg == IGNT)  && iREN && (ramstate == ACCESS);
    assign dr_done = (state_reg == DRGNT) && dREN && (ramstate == ACCESS);
    assign dw_done = (state_reg == DWGNT) && (ramstate == ACCESS);

    assign iwait    = !i_done;
    assign iload    = i_done ? ramload : '0;
    assign dwait    = !(dr_done || dw_done);
    assign dload    = dr_done ? ramload : '0;
    assign ramREN   = ren_reg;
    assign ramWEN   = wen_reg;
    assign ramaddr  = addr_reg;
    assign ramstore = data_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (starved)   state_next = IGNT;
                else if (dWEN) state_next = DWGNT;
                else if (dREN) state_next = DRGNT;
                else if (iREN) state_next = IGNT;
            end
            IGNT: begin
                if (!iREN || ramstate == ACCESS) state_next = IDLE;
                else if (ramstate == ERROR)      state_next = RETRY;
            end
            DRGNT: begin
                if (!dREN || ramstate == ACCESS) state_next = IDLE;
                else if (ramstate == ERROR)      state_next = RETRY;
            end
            DWGNT: begin
                if (ramstate == ACCESS)     state_next = IDLE;
                else if (ramstate == ERROR) state_next = RETRY;
            end
            RETRY:   state_next = state_of(saved_reg);
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= IDLE;
            saved_reg <= GNT_I;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            data_reg  <= '0;
            ren_reg   <= 1'b0;
            wen_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ren_reg   <= (state_next == IGNT) || (state_next == DRGNT);
            wen_reg   <= (state_next == DWGNT);
            if (state_next == RETRY) begin
                saved_reg <= grant_of(state_reg);
            end
            // Request is latched only when leaving IDLE; retries reuse it.
            if (state_reg == IDLE) begin
                case (state_next)
                    IGNT: begin
                        addr_reg <= iaddr;
                        cnt_reg  <= '0;
                    end
                    DRGNT: begin
                        addr_reg <= daddr;
                        cnt_reg  <= cnt_next;
                    end
                    DWGNT: begin
                        addr_reg <= daddr;
                        data_reg <= dstore;
                        cnt_reg  <= cnt_next;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand-written
// sequences for starvation, error retry, withdrawal and asynchronous reset.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic      CLK = 1'b0;
    logic      nRST = 1'b0;
    logic      iREN = 1'b0;
    word_t     iaddr = '0;
    logic      iwait;
    word_t     iload;
    logic      dREN = 1'b0;
    logic      dWEN = 1'b0;
    word_t     daddr = '0;
    word_t     dstore = '0;
    logic      dwait;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload = '0;
    ramstate_t ramstate = FREE;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic       ir;
        word_t      ia;
        logic       dr;
        logic       dw;
        word_t      da;
        word_t      ds;
        logic [1:0] rs;
        word_t      rl;
        logic       e_ren;
        logic       e_wen;
        word_t      e_addr;
        word_t      e_store;
        logic       e_iwait;
        logic       e_dwait;
        word_t      e_iload;
        word_t      e_dload;
    } vec_t;

    vec_t vecs[12];

    mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step(input logic ir, input word_t ia, input logic dr, input logic dw,
                        input word_t da, input word_t ds, input ramstate_t rs, input word_t rl);
        @(posedge CLK);
        #1;
        iREN = ir; iaddr = ia; dREN = dr; dWEN = dw;
        daddr = da; dstore = ds; ramstate = rs; ramload = rl;
        #1;
    endtask

    initial begin
        // icache fill with 3 strobe cycles, then DW / DR / I triple request
        vecs[0]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,        2'd0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 32'h0,        32'h0};
        vecs[1]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,        2'd1, 32'h0,        1'b1, 1'b0, 32'h40,  32'h0,        1'b1, 1'b1, 32'h0,        32'h0};
        vecs[2]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,        2'd1, 32'h0,        1'b1, 1'b0, 32'h40,  32'h0,        1'b1, 1'b1, 32'h0,        32'h0};
        vecs[3]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,        2'd2, 32'h8C220004, 1'b1, 1'b0, 32'h40,  32'h0,        1'b0, 1'b1, 32'h8C220004, 32'h0};
        vecs[4]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        2'd0, 32'h0,        1'b0, 1'b0, 32'h40,  32'h0,        1'b1, 1'b1, 32'h0,        32'h0};
        vecs[5]  = '{1'b1, 32'h80, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 2'd0, 32'h0,        1'b0, 1'b0, 32'h40,  32'h0,        1'b1, 1'b1, 32'h0,        32'h0};
        vecs[6]  = '{1'b1, 32'h80, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 2'd2, 32'h0,        1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        32'h0};
        vecs[7]  = '{1'b1, 32'h80, 1'b1, 1'b0, 32'h204, 32'hDEADBEEF, 2'd0, 32'h0,        1'b0, 1'b0, 32'h200, 32'hDEADBEEF, 1'b1, 1'b1, 32'h0,        32'h0};
        vecs[8]  = '{1'b1, 32'h80, 1'b1, 1'b0, 32'h204, 32'hDEADBEEF, 2'd2, 32'h11112222, 1'b1, 1'b0, 32'h204, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        32'h11112222};
        vecs[9]  = '{1'b1, 32'h80, 1'b0, 1'b0, 32'h204, 32'hDEADBEEF, 2'd0, 32'h0,        1'b0, 1'b0, 32'h204, 32'hDEADBEEF, 1'b1, 1'b1, 32'h0,        32'h0};
        vecs[10] = '{1'b1, 32'h80, 1'b0, 1'b0, 32'h204, 32'hDEADBEEF, 2'd2, 32'h33334444, 1'b1, 1'b0, 32'h80,  32'hDEADBEEF, 1'b0, 1'b1, 32'h33334444, 32'h0};
        vecs[11] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        2'd0, 32'h0,        1'b0, 1'b0, 32'h80,  32'hDEADBEEF, 1'b1, 1'b1, 32'h0,        32'h0};

        // Reset values
        #2;
        check("reset ramREN",   32'(ramREN),   32'd0);
        check("reset ramWEN",   32'(ramWEN),   32'd0);
        check("reset ramaddr",  ramaddr,       32'h0);
        check("reset ramstore", ramstore,      32'h0);
        check("reset iwait",    32'(iwait),    32'd1);
        check("reset dwait",    32'(dwait),    32'd1);
        check("reset iload",    iload,         32'h0);
        check("reset dload",    dload,         32'h0);
        @(posedge CLK);
        #1 nRST = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(posedge CLK);
            #1;
            iREN = vecs[i].ir; iaddr = vecs[i].ia; dREN = vecs[i].dr; dWEN = vecs[i].dw;
            daddr = vecs[i].da; dstore = vecs[i].ds;
            ramstate = ramstate_t'(vecs[i].rs); ramload = vecs[i].rl;
            #1;
            check($sformatf("v%0d ramREN", i),   32'(ramREN),  32'(vecs[i].e_ren));
            check($sformatf("v%0d ramWEN", i),   32'(ramWEN),  32'(vecs[i].e_wen));
            check($sformatf("v%0d ramaddr", i),  ramaddr,      vecs[i].e_addr);
            check($sformatf("v%0d ramstore", i), ramstore,     vecs[i].e_store);
            check($sformatf("v%0d iwait", i),    32'(iwait),   32'(vecs[i].e_iwait));
            check($sformatf("v%0d dwait", i),    32'(dwait),   32'(vecs[i].e_dwait));
            check($sformatf("v%0d iload", i),    iload,        vecs[i].e_iload);
            check($sformatf("v%0d dload", i),    dload,        vecs[i].e_dload);
        end

        // Starvation: dREN held with iREN pending -> D,D,D,D,I,D
        for (int k = 0; k < 6; k++) begin
            logic exp_i;
            exp_i = (k == 4);
            step(1'b1, 32'h300, 1'b1, 1'b0, 32'h400, 32'h0, ACCESS, 32'h0);
            check($sformatf("starve%0d idle ramREN", k), 32'(ramREN), 32'd0);
            step(1'b1, 32'h300, 1'b1, 1'b0, 32'h400, 32'h0, ACCESS, 32'h0);
            check($sformatf("starve%0d ramREN", k),  32'(ramREN),  32'd1);
            check($sformatf("starve%0d ramaddr", k), ramaddr,      exp_i ? 32'h300 : 32'h400);
            check($sformatf("starve%0d iwait", k),   32'(iwait),   32'(!exp_i));
            check($sformatf("starve%0d dwait", k),   32'(dwait),   32'(exp_i));
        end
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        check("starve end ramREN", 32'(ramREN), 32'd0);

        // ERROR for one cycle -> RETRY -> reissue at the latched address
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, FREE, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, ERROR, 32'h0);
        check("err grant ramREN",  32'(ramREN), 32'd1);
        check("err grant ramaddr", ramaddr,     32'h100);
        check("err grant dwait",   32'(dwait),  32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, FREE, 32'h0);
        check("retry ramREN", 32'(ramREN), 32'd0);
        check("retry ramWEN", 32'(ramWEN), 32'd0);
        check("retry dwait",  32'(dwait),  32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, BUSY, 32'h0);
        check("reissue ramREN",  32'(ramREN), 32'd1);
        check("reissue ramaddr", ramaddr,     32'h100);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, ACCESS, 32'hCAFEF00D);
        check("reissue dwait", 32'(dwait), 32'd0);
        check("reissue dload", dload,      32'hCAFEF00D);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        check("reissue done ramREN", 32'(ramREN), 32'd0);

        // Read withdrawn during BUSY -> abort with no wait pulse
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0, FREE, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0, BUSY, 32'h0);
        check("wdr grant ramREN", 32'(ramREN), 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h500, 32'h0, BUSY, 32'h0);
        check("wdr drop dwait", 32'(dwait), 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h500, 32'h0, ACCESS, 32'h77);
        check("wdr after ramREN", 32'(ramREN), 32'd0);
        check("wdr after dwait",  32'(dwait),  32'd1);
        check("wdr after dload",  dload,       32'h0);

        // Write withdrawn during BUSY -> write still runs to ACCESS
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h600, 32'h12345678, FREE, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h600, 32'h12345678, BUSY, 32'h0);
        check("wdw grant ramWEN",   32'(ramWEN), 32'd1);
        check("wdw grant ramstore", ramstore,    32'h12345678);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0);
        check("wdw drop ramWEN", 32'(ramWEN), 32'd1);
        check("wdw drop dwait",  32'(dwait),  32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0);
        check("wdw busy ramWEN", 32'(ramWEN), 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS, 32'h99);
        check("wdw done dwait",  32'(dwait),  32'd0);
        check("wdw done dload",  dload,       32'h0);
        check("wdw done ramREN", 32'(ramREN), 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        check("wdw idle ramWEN", 32'(ramWEN), 32'd0);

        // Asynchronous reset in the middle of a write grant
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h700, 32'hAAAA5555, FREE, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h700, 32'hAAAA5555, ACCESS, 32'h0);
        check("rst pre ramWEN", 32'(ramWEN), 32'd1);
        check("rst pre dwait",  32'(dwait),  32'd0);
        #1 nRST = 1'b0;
        #1;
        check("rst async ramWEN",  32'(ramWEN), 32'd0);
        check("rst async dwait",   32'(dwait),  32'd1);
        check("rst async ramaddr", ramaddr,     32'h0);
        #1;
        dWEN = 1'b0; ramstate = FREE; nRST = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        check("rst idle ramREN", 32'(ramREN), 32'd0);
        check("rst idle ramWEN", 32'(ramWEN), 32'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, FREE, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, ACCESS, 32'h55);
        check("post rst ramREN",  32'(ramREN), 32'd1);
        check("post rst ramaddr", ramaddr,     32'h10);
        check("post rst dwait",   32'(dwait),  32'd0);
        check("post rst dload",   dload,       32'h55);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
